// File: rtl/i2c_target_responder.sv
// i2c_target_responder
// I2C target that answers at DEV_ADDR and maps bus transfers onto a simple
// register-pointer interface: the first written byte sets reg_addr, each
// further written byte is presented on wr_data with a wr_strobe pulse, and
// reads stream rd_data out starting at reg_addr. The pointer auto-increments
// after every data byte and wraps from 8'hFF to 8'h00.
//
// Ports:
//   clock      system clock, all logic
//   reset      asynchronous active-high reset
//   scl_in     raw bus SCL (asynchronous)
//   sda_in     raw bus SDA (asynchronous)
//   sda_oe     1 pulls SDA low, 0 releases it
//   reg_addr   current register pointer
//   wr_data    last data byte written by the master
//   wr_strobe  one-clock pulse, wr_data valid for reg_addr
//   rd_data    register contents at reg_addr from user logic
//   busy       high whenever the FSM is not idle
//
// state      | meaning
// IDLE       | bus free, waiting for START
// DEV_ADDR   | shifting in the address/RW byte
// ACK_DEV    | driving ACK for our address
// REG_ADDR   | shifting in the register pointer byte
// ACK_REG    | driving ACK for the pointer byte
// WR_DATA    | shifting in a write data byte
// ACK_WR     | driving ACK for a data byte
// RD_DATA    | driving a read byte, MSB first
// RD_ACK     | released, sampling master ACK/NACK
// WAIT_STOP  | not addressed or read finished, waiting for STOP
module i2c_target_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h1D
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_strobe,
  input  logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_DEV_ADDR, ST_ACK_DEV, ST_REG_ADDR, ST_ACK_REG,
    ST_WR_DATA, ST_ACK_WR, ST_RD_DATA, ST_RD_ACK, ST_WAIT_STOP
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  scl_sync, sda_sync;
  logic [3:0]  bit_cnt;
  logic [7:0]  shift_q;
  logic [7:0]  rx_byte;
  logic        fall_d1, master_ack;
  logic        scl_rise, scl_fall, scl_hi2, start_det, stop_det;
  logic        rx_state, byte_last_rise, drive_d;

  // [1] is the synchronized value, [2] the previous sample for edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_sync <= 3'b111;
      sda_sync <= 3'b111;
    end else begin
      scl_sync <= {scl_sync[1:0], scl_in};
      sda_sync <= {sda_sync[1:0], sda_in};
    end
  end

  assign scl_rise  = scl_sync[1] & ~scl_sync[2];
  assign scl_fall  = ~scl_sync[1] & scl_sync[2];
  assign scl_hi2   = scl_sync[1] & scl_sync[2];
  // requiring SCL high on both samples rejects coincident SCL/SDA edges
  assign start_det = scl_hi2 & ~sda_sync[1] & sda_sync[2];
  assign stop_det  = scl_hi2 & sda_sync[1] & ~sda_sync[2];

  assign rx_byte        = {shift_q[6:0], sda_sync[1]};
  assign rx_state       = (state_q == ST_DEV_ADDR) || (state_q == ST_REG_ADDR) ||
                          (state_q == ST_WR_DATA);
  assign byte_last_rise = rx_state & scl_rise & (bit_cnt == 4'd7);
  assign busy           = (state_q != ST_IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Receive states hold bit_cnt at 8 after the last rise so the ACK state is
  // entered on the following fall, not on the rise that completed the byte.
  always_comb begin
    state_d = state_q;
    drive_d = 1'b0;
    case (state_q)
      ST_ACK_DEV, ST_ACK_REG, ST_ACK_WR: drive_d = 1'b1;
      ST_RD_DATA:                        drive_d = ~shift_q[7];
      default:                           drive_d = 1'b0;
    endcase
    if (start_det) begin
      state_d = ST_DEV_ADDR;
    end else if (stop_det) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_DEV_ADDR:
          if (byte_last_rise && (rx_byte[7:1] != DEV_ADDR)) state_d = ST_WAIT_STOP;
          else if (scl_fall && (bit_cnt == 4'd8))           state_d = ST_ACK_DEV;
        ST_ACK_DEV:  if (scl_fall) state_d = shift_q[0] ? ST_RD_DATA : ST_REG_ADDR;
        ST_REG_ADDR: if (scl_fall && (bit_cnt == 4'd8)) state_d = ST_ACK_REG;
        ST_ACK_REG:  if (scl_fall) state_d = ST_WR_DATA;
        ST_WR_DATA:  if (scl_fall && (bit_cnt == 4'd8)) state_d = ST_ACK_WR;
        ST_ACK_WR:   if (scl_fall) state_d = ST_WR_DATA;
        ST_RD_DATA:  if (scl_fall && (bit_cnt == 4'd7)) state_d = ST_RD_ACK;
        ST_RD_ACK:   if (scl_fall) state_d = master_ack ? ST_RD_DATA : ST_WAIT_STOP;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt    <= '0;
      shift_q    <= '0;
      reg_addr   <= '0;
      wr_data    <= '0;
      wr_strobe  <= 1'b0;
      sda_oe     <= 1'b0;
      fall_d1    <= 1'b0;
      master_ack <= 1'b0;
    end else begin
      wr_strobe <= 1'b0;
      fall_d1   <= scl_fall;
      if (start_det || stop_det) begin
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
      end else begin
        if (rx_state && scl_rise && (bit_cnt != 4'd8)) begin
          shift_q <= rx_byte;
          bit_cnt <= bit_cnt + 4'd1;
        end
        if (byte_last_rise && (state_q == ST_REG_ADDR)) reg_addr <= rx_byte;
        if (byte_last_rise && (state_q == ST_WR_DATA)) begin
          wr_data   <= rx_byte;
          wr_strobe <= 1'b1;
        end
        if (scl_fall && (state_q == ST_RD_DATA) && (state_d == ST_RD_DATA)) begin
          shift_q <= {shift_q[6:0], 1'b0};
          bit_cnt <= bit_cnt + 4'd1;
        end
        if (scl_fall && (state_d != state_q)) bit_cnt <= '0;
        if (scl_rise && (state_q == ST_RD_ACK)) master_ack <= ~sda_sync[1];
        if (scl_fall && ((state_q == ST_ACK_WR) || (state_q == ST_RD_ACK)))
          reg_addr <= reg_addr + 8'd1;
        // One cycle after the fall the pointer has settled, so rd_data already
        // reflects the incremented address when a read byte is loaded.
        if (fall_d1) begin
          if ((state_q == ST_RD_DATA) && (bit_cnt == 4'd0)) begin
            shift_q <= rd_data;
            sda_oe  <= ~rd_data[7];
          end else begin
            sda_oe <= drive_d;
          end
        end
      end
    end
  end

endmodule
